// File: rtl/fetch_buffer.sv
// -----------------------------------------------------------------------------
// fetch_buffer
//
// Instruction queue sitting between fetch and decode. Fetch pushes {pc, instr}
// pairs; decode pops the oldest entry through a valid/ready handshake. A
// redirect (flush) discards every stored entry.
//
// Optional build macro:
//   FETCH_BUF_BYPASS_EN - when the queue is empty (and no flush), the incoming
//                         entry is presented to decode in the same cycle and,
//                         if taken, never stored (zero-cycle latency).
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   flush      in   redirect, drops all entries (sampled at the clock edge)
//   in_valid   in   fetch presents {in_pc, in_instr}
//   in_pc      in   PC of fetched instruction
//   in_instr   in   fetched instruction word
//   in_ready   out  buffer can accept an entry (registered state only)
//   out_valid  out  head entry valid for decode
//   out_pc     out  PC of head entry (0 when not valid)
//   out_instr  out  instruction of head entry (0 when not valid)
//   out_npc    out  out_pc + 4 (0 when not valid)
//   out_ready  in   decode consumes head entry
//   count      out  number of stored entries, 0..DEPTH
// -----------------------------------------------------------------------------
module fetch_buffer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [31:0]      in_pc,
    input  logic [31:0]      in_instr,
    output logic             in_ready,
    output logic             out_valid,
    output logic [31:0]      out_pc,
    output logic [31:0]      out_instr,
    output logic [31:0]      out_npc,
    input  logic             out_ready,
    output logic [PTR_W:0]   count
);

    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q,  count_d;

    // Storage is deliberately not reset; pointers/count alone define validity.
    logic [31:0] pc_mem    [DEPTH];
    logic [31:0] instr_mem [DEPTH];

    logic        stored_valid;
    logic        push;
    logic        pop;
    logic [31:0] head_pc;
    logic [31:0] head_instr;

    assign stored_valid = (count_q != '0);

    // Full check uses registered count only, so a same-cycle pop never
    // opens the input and there is no out_ready -> in_ready path.
    assign in_ready = (count_q != CNT_FULL);

`ifdef FETCH_BUF_BYPASS_EN
    logic bypass_sel;

    // Empty queue: route fetch straight through to decode.
    assign bypass_sel = (count_q == '0) && !flush;
    // Gate with reset so the pass-through path stays quiet while held in reset.
    assign out_valid  = reset && (bypass_sel ? in_valid : stored_valid);
    assign head_pc    = bypass_sel ? in_pc    : pc_mem[rd_ptr_q];
    assign head_instr = bypass_sel ? in_instr : instr_mem[rd_ptr_q];
    // An entry consumed directly from the input is never written.
    assign push       = in_valid && in_ready && !(bypass_sel && out_ready);
    assign pop        = stored_valid && out_ready;
`else
    assign out_valid  = stored_valid;
    assign head_pc    = pc_mem[rd_ptr_q];
    assign head_instr = instr_mem[rd_ptr_q];
    assign push       = in_valid && in_ready;
    assign pop        = out_valid && out_ready;
`endif

    assign out_pc    = out_valid ? head_pc          : 32'd0;
    assign out_instr = out_valid ? head_instr       : 32'd0;
    assign out_npc   = out_valid ? head_pc + 32'd4  : 32'd0;
    assign count     = count_q;

    // Next-state: flush dominates push and pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            if (push && !pop) begin
                count_d = count_q + CNT_ONE;
            end else if (pop && !push) begin
                count_d = count_q - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // One write port per entry; pointer wrap is natural since DEPTH = 2**PTR_W.
    // A write during flush is harmless: the slot is unreachable after the reset
    // of the pointers and will be overwritten before it is read.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (push && (wr_ptr_q == PTR_W'(gi))) begin
                pc_mem[gi]    <= in_pc;
                instr_mem[gi] <= in_instr;
            end
        end
    end

endmodule

// File: tb/tb_fetch_buffer.sv
module tb_fetch_buffer;

    localparam int DEPTH = 4;
    localparam int PTR_W = 2;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic [31:0]      in_pc = 32'd0;
    logic [31:0]      in_instr = 32'd0;
    logic             in_ready;
    logic             out_valid;
    logic [31:0]      out_pc;
    logic [31:0]      out_instr;
    logic [31:0]      out_npc;
    logic             out_ready = 1'b0;
    logic [PTR_W:0]   count;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    // Reference model: a plain FIFO of entries.
    entry_t q[$];

    fetch_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .out_npc   (out_npc),
        .out_ready (out_ready),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare every output against the model,
    // then advance the model across the rising edge.
    task automatic step(input logic f, input logic iv, input logic [31:0] pc,
                        input logic [31:0] ins, input logic ordy);
        logic        bypass;
        logic        exp_valid;
        logic        exp_ready;
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
        int          n;
        flush     = f;
        in_valid  = iv;
        in_pc     = pc;
        in_instr  = ins;
        out_ready = ordy;
        #1;
        n = q.size();
        bypass = 1'b0;
`ifdef FETCH_BUF_BYPASS_EN
        bypass = (n == 0) && !f;
`endif
        exp_ready = (n != DEPTH);
        if (bypass) begin
            exp_valid = iv;
            exp_pc    = iv ? pc  : 32'd0;
            exp_instr = iv ? ins : 32'd0;
        end else if (n != 0) begin
            exp_valid = 1'b1;
            exp_pc    = q[0].pc;
            exp_instr = q[0].instr;
        end else begin
            exp_valid = 1'b0;
            exp_pc    = 32'd0;
            exp_instr = 32'd0;
        end
        check("count",     32'(count),     32'(n));
        check("in_ready",  32'(in_ready),  32'(exp_ready));
        check("out_valid", 32'(out_valid), 32'(exp_valid));
        check("out_pc",    out_pc,         exp_pc);
        check("out_instr", out_instr,      exp_instr);
        check("out_npc",   out_npc,        exp_valid ? exp_pc + 32'd4 : 32'd0);
        @(posedge clk);
        if (f) begin
            q.delete();
        end else if (!(bypass && iv && ordy)) begin
            if (exp_valid && ordy) void'(q.pop_front());
            if (iv && exp_ready) q.push_back(entry_t'{pc, ins});
        end
        @(negedge clk);
    endtask

    initial begin
        logic        r_f;
        logic        r_iv;
        logic        r_ordy;
        logic [31:0] r_pc;
        logic [31:0] r_ins;
        logic        hold;

        // Reset held for three cycles, outputs checked while in reset.
        repeat (3) @(negedge clk);
        check("rst_count",     32'(count),     32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_pc",    out_pc,         32'd0);
        check("rst_out_npc",   out_npc,        32'd0);
        reset = 1'b1;
        step(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);

        // Fill to full with decode stalled.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 32'(i * 4), $urandom(), 1'b0);
        step(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);

        // Full: pop happens, push of 0x10 is refused, then accepted.
        step(1'b0, 1'b1, 32'h10, 32'hAAAA_0010, 1'b1);
        step(1'b0, 1'b1, 32'h10, 32'hAAAA_0010, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1);

        // Streaming across pointer wrap.
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 32'h100 + 32'(i * 4), $urandom(), 1'b1);
        step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
        step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1);

        // Flush beats push and pop.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 32'h80 + 32'(i * 4), $urandom(), 1'b0);
        step(1'b1, 1'b1, 32'h200, 32'hDEAD_0200, 1'b1);
        step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1);

        // Asynchronous reset between edges.
        step(1'b0, 1'b1, 32'h30, $urandom(), 1'b0);
        step(1'b0, 1'b1, 32'h34, $urandom(), 1'b0);
        in_valid = 1'b0;
        out_ready = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("async_rst_count",     32'(count),     32'd0);
        check("async_rst_out_valid", 32'(out_valid), 32'd0);
        check("async_rst_in_ready",  32'(in_ready),  32'd1);
        q.delete();
        @(negedge clk);
        reset = 1'b1;
        step(1'b0, 1'b1, 32'h40, 32'h0000_0040, 1'b0);
        step(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1);

        // Random traffic; fetch holds its entry while refused.
        hold  = 1'b0;
        r_iv  = 1'b0;
        r_pc  = 32'd0;
        r_ins = 32'd0;
        for (int i = 0; i < 400; i++) begin
            r_f    = ($urandom_range(0, 24) == 0);
            r_ordy = $urandom_range(0, 1) == 1;
            if (!hold) begin
                r_iv  = $urandom_range(0, 2) != 0;
                r_pc  = $urandom() & 32'hFFFF_FFFC;
                r_ins = $urandom();
            end
            hold = r_iv && (q.size() == DEPTH) && !r_f;
            step(r_f, r_iv, r_pc, r_ins, r_ordy);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
